mem_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU. Consumes its result, destination register, effective address and store data.
- Non-memory ops: passes the result through to writeback.
- Loads/stores: runs one transaction on a 64-bit request/grant/response data bus, then emits the writeback.
- Stalls the ALU through a ready signal while a transaction is outstanding.

---
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: request/grant/response data bus between the memory stage and memory.
// The stage is the master; the memory (or a testbench) is the slave.
interface mem_stage_if #(
    parameter int ADDR_W = 64
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline stage after the ALU; passes ALU results through and runs loads/stores on the bus.
// Define MEM_STAGE_MISALIGN_FAULT_EN to turn misaligned accesses into a one-cycle fault pulse.
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    mem_stage_if.master     bus,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [2:0]  off;
    logic [2:0]  lat_off;
    logic [2:0]  lat_f3;
    logic [4:0]  lat_rd;
    logic        is_load;
    logic        is_store;
    logic        accept;
    logic        bad_align;
    logic [7:0]  strb;
    logic [63:0] shifted;
    logic [63:0] load_val;

    assign off      = in_addr[2:0];
    assign accept   = in_valid && in_ready && (state == IDLE);
    assign is_load  = (in_kind == 2'd1) && (in_funct3 != 3'b111);
    assign is_store = (in_kind == 2'd2) && !in_funct3[2];

    // Lanes shifted past byte 7 fall off the 8-bit strobe, which is the truncation for boundary crossers.
    always_comb begin
        case (in_funct3[1:0])
            2'd0:    strb = 8'h01 << off;
            2'd1:    strb = 8'h03 << off;
            2'd2:    strb = 8'h0F << off;
            default: strb = 8'hFF;
        endcase
    end

    assign shifted = bus.mem_rdata >> {lat_off, 3'b000};

    always_comb begin
        case (lat_f3)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_FAULT_EN
    always_comb begin
        case (in_funct3[1:0])
            2'd0:    bad_align = 1'b0;
            2'd1:    bad_align = off[0];
            2'd2:    bad_align = |off[1:0];
            default: bad_align = |off;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) fault <= 1'b0;
        else       fault <= accept && (is_load || is_store) && bad_align;
    end
`else
    assign bad_align = 1'b0;
    assign fault     = 1'b0;
`endif

    // Main FSM; mem_* stay frozen from acceptance until the grant edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 64'd0;
            bus.mem_wstrb <= 8'd0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= '0;
            lat_off       <= 3'd0;
            lat_f3        <= 3'd0;
            lat_rd        <= 5'd0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if ((is_load || is_store) && !bad_align) begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_store;
                            bus.mem_addr  <= ADDR_W'({in_addr[XLEN-1:3], 3'b000});
                            bus.mem_wdata <= is_store ? (64'(in_wdata) << {off, 3'b000}) : 64'd0;
                            bus.mem_wstrb <= is_store ? strb : 8'd0;
                            lat_off       <= off;
                            lat_f3        <= in_funct3;
                            lat_rd        <= in_rd;
                            in_ready      <= 1'b0;
                            state         <= REQ;
                        end else if (!(is_load || is_store)) begin
                            wb_valid <= (in_rd != 5'd0);
                            wb_rd    <= in_rd;
                            wb_data  <= in_result;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (!bus.mem_we) begin
                            wb_valid <= (lat_rd != 5'd0);
                            wb_rd    <= lat_rd;
                            wb_data  <= XLEN'(load_val);
                        end
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with a byte-level reference model.
// Honours MEM_STAGE_MISALIGN_FAULT_EN the same way the design does.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [63:0] in_result = 64'd0;
    logic [63:0] in_addr = 64'd0;
    logic [63:0] in_wdata = 64'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        fault;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;
    wb_t exp_wb[$];

    logic        exp_txn_valid = 1'b0;
    logic [63:0] exp_addr = 64'd0;
    logic        exp_we = 1'b0;
    logic [7:0]  exp_strb = 8'd0;
    logic [63:0] exp_wdata = 64'd0;
    logic        exp_fault = 1'b0;

    mem_stage_if #(.ADDR_W(64)) bus ();

    mem_stage #(.XLEN(64), .ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_result (in_result),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .bus       (bus),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: byte lanes computed directly from access size and offset.
    function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [2:0] off);
        int nbytes;
        logic [7:0] s;
        nbytes = 1 << f3[1:0];
        s = 8'h00;
        if (nbytes == 8) return 8'hFF;
        for (int i = 0; i < nbytes; i++)
            if (int'(off) + i < 8) s[int'(off) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] wdata, input logic [2:0] off);
        return wdata << (8 * int'(off));
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] rdata);
        int nbytes;
        logic [63:0] v;
        nbytes = 1 << f3[1:0];
        v = 64'd0;
        for (int i = 0; i < nbytes; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = rdata[8*(int'(off) + i) +: 8];
        if (!f3[2] && nbytes < 8 && v[8*nbytes - 1])
            for (int i = nbytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic pushWb(input logic [4:0] rd, input logic [63:0] data);
        wb_t e;
        e.rd = rd;
        e.data = data;
        exp_wb.push_back(e);
    endtask

    // Scoreboard compare: writebacks, bus request contents and fault every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                if (exp_wb.size() == 0) begin
                    checkOutput("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    wb_t e;
                    e = exp_wb.pop_front();
                    checkOutput("wb_rd", wb_rd, e.rd);
                    checkOutput("wb_data", wb_data, e.data);
                end
            end
            if (bus.mem_req) begin
                checkOutput("req_expected", bus.mem_req, exp_txn_valid);
                checkOutput("mem_addr", bus.mem_addr, exp_addr);
                checkOutput("mem_we", bus.mem_we, exp_we);
                checkOutput("mem_wstrb", bus.mem_wstrb, exp_strb);
                if (exp_we) checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            checkOutput("fault", fault, exp_fault);
        end
    end

    // Waits (bounded) for in_ready, presents one op for one accepting edge, returns #1 after it.
    task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [63:0] result, input logic [63:0] addr, input logic [63:0] wdata);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("accept_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_funct3 = f3;
        in_rd     = rd;
        in_result = result;
        in_addr   = addr;
        in_wdata  = wdata;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic aluOp(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] result, input string name);
        if (rd != 5'd0) pushWb(rd, result);
        applyStimulus(kind, f3, rd, result, 64'h0000_0000_0000_1000, 64'd0);
        checkOutput({name, "_wb_valid"}, wb_valid, (rd != 5'd0));
        checkOutput({name, "_ready"}, in_ready, 1'b1);
        checkOutput({name, "_no_req"}, bus.mem_req, 1'b0);
    endtask

    task automatic memOp(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input int gnt_delay, input int rv_delay, input logic [63:0] rdata,
                         input string name);
        logic [2:0] off;
        logic is_ld;
        off = addr[2:0];
        is_ld = (kind == 2'd1);
        exp_addr      = {addr[63:3], 3'b000};
        exp_we        = !is_ld;
        exp_strb      = is_ld ? 8'h00 : model_strb(f3, off);
        exp_wdata     = model_wdata(wdata, off);
        exp_txn_valid = 1'b1;
        applyStimulus(kind, f3, rd, 64'hDEAD_0000_0000_BEEF, addr, wdata);
        checkOutput({name, "_req"}, bus.mem_req, 1'b1);
        checkOutput({name, "_ready_lo"}, in_ready, 1'b0);
        for (int i = 0; i < gnt_delay; i++) begin
            @(posedge clk); #1;
            checkOutput({name, "_req_held"}, bus.mem_req, 1'b1);
            checkOutput({name, "_ready_held"}, in_ready, 1'b0);
        end
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        exp_txn_valid = 1'b0;
        checkOutput({name, "_req_drop"}, bus.mem_req, 1'b0);
        for (int i = 1; i < rv_delay; i++) begin
            @(posedge clk); #1;
            checkOutput({name, "_ready_wait"}, in_ready, 1'b0);
        end
        if (is_ld && rd != 5'd0) pushWb(rd, model_load(f3, off, rdata));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        checkOutput({name, "_wb_valid"}, wb_valid, (is_ld && rd != 5'd0));
        checkOutput({name, "_ready_back"}, in_ready, 1'b1);
    endtask

`ifdef MEM_STAGE_MISALIGN_FAULT_EN
    task automatic faultOp(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] addr, input logic [63:0] wdata, input string name);
        applyStimulus(kind, f3, rd, 64'd0, addr, wdata);
        exp_fault = 1'b1;
        checkOutput({name, "_fault"}, fault, 1'b1);
        checkOutput({name, "_no_req"}, bus.mem_req, 1'b0);
        checkOutput({name, "_ready"}, in_ready, 1'b1);
        checkOutput({name, "_no_wb"}, wb_valid, 1'b0);
        @(posedge clk); #1;
        exp_fault = 1'b0;
        checkOutput({name, "_fault_end"}, fault, 1'b0);
        checkOutput({name, "_no_req2"}, bus.mem_req, 1'b0);
        checkOutput({name, "_ready2"}, in_ready, 1'b1);
    endtask
`endif

    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_mem_req", bus.mem_req, 1'b0);
        checkOutput("rst_mem_we", bus.mem_we, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 64'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 64'd0);
        checkOutput("rst_mem_wstrb", bus.mem_wstrb, 8'd0);
        checkOutput("rst_wb_valid", wb_valid, 1'b0);
        checkOutput("rst_wb_rd", wb_rd, 5'd0);
        checkOutput("rst_wb_data", wb_data, 64'd0);
        checkOutput("rst_fault", fault, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_ready", in_ready, 1'b1);

        // Model pins against hand-computed values.
        checkOutput("pin_lb", model_load(3'b000, 3'd3, 64'h0000_0000_80FF_0000), 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("pin_lhu", model_load(3'b101, 3'd2, 64'h0000_0000_ABCD_0000), 64'h0000_0000_0000_ABCD);
        checkOutput("pin_sw_strb", model_strb(3'b010, 3'd4), 8'hF0);
        checkOutput("pin_sw_wdata", model_wdata(64'hDEAD_BEEF, 3'd4), 64'hDEAD_BEEF_0000_0000);
        checkOutput("pin_sw_cross_strb", model_strb(3'b010, 3'd6), 8'hC0);

        // Back-to-back ALU ops at full throughput.
        for (int i = 0; i < 3; i++) pushWb(5'd5, 64'h1234);
        in_valid = 1'b1; in_kind = 2'd0; in_funct3 = 3'd0; in_rd = 5'd5; in_result = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("alu_b2b_wb_valid", wb_valid, 1'b1);
            checkOutput("alu_b2b_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("alu_b2b_pulse_end", wb_valid, 1'b0);

        memOp(2'd1, 3'b000, 5'd3, 64'h1003, 64'd0, 0, 1, 64'h0000_0000_80FF_0000, "lb");
        memOp(2'd1, 3'b101, 5'd4, 64'h2002, 64'd0, 3, 2, 64'h0000_0000_ABCD_0000, "lhu");
        memOp(2'd2, 3'b010, 5'd6, 64'h3004, 64'hDEAD_BEEF, 1, 1, 64'd0, "sw");
`ifdef MEM_STAGE_MISALIGN_FAULT_EN
        faultOp(2'd2, 3'b010, 5'd6, 64'h3006, 64'hDEAD_BEEF, "sw_cross");
`else
        memOp(2'd2, 3'b010, 5'd6, 64'h3006, 64'hDEAD_BEEF, 0, 1, 64'd0, "sw_cross");
`endif
        memOp(2'd1, 3'b010, 5'd7, 64'h5004, 64'd0, 0, 1, 64'h8765_4321_0000_0000, "lw");
        memOp(2'd1, 3'b110, 5'd8, 64'h5004, 64'd0, 1, 3, 64'h8765_4321_0000_0000, "lwu");
        memOp(2'd1, 3'b011, 5'd9, 64'h6000, 64'd0, 0, 1, 64'hFEDC_BA98_7654_3210, "ld");
        memOp(2'd1, 3'b001, 5'd10, 64'h6006, 64'd0, 0, 1, 64'h9ABC_0000_0000_0000, "lh");
        memOp(2'd2, 3'b000, 5'd1, 64'h7005, 64'h0000_0000_0000_00AB, 0, 1, 64'd0, "sb");
        memOp(2'd2, 3'b001, 5'd1, 64'h7006, 64'h0000_0000_0000_55AA, 2, 1, 64'd0, "sh");
        memOp(2'd2, 3'b011, 5'd1, 64'h7000, 64'h0123_4567_89AB_CDEF, 0, 2, 64'd0, "sd");

        // Unsupported encodings fall back to ALU pass-through.
        aluOp(2'd1, 3'b111, 5'd9, 64'h0ABC, "ld_f3_111");
        aluOp(2'd2, 3'b100, 5'd11, 64'h5555, "st_f3_100");
        aluOp(2'd3, 3'b000, 5'd12, 64'hCAFE, "kind_rsvd");
        aluOp(2'd0, 3'b000, 5'd0, 64'h9999, "alu_rd0");

        memOp(2'd1, 3'b010, 5'd0, 64'h8000, 64'd0, 0, 1, 64'h1111_2222_3333_4444, "lw_rd0");

        // Reset while waiting for the response; the late response must be ignored.
        exp_addr = 64'h9000; exp_we = 1'b0; exp_strb = 8'h00; exp_wdata = 64'd0; exp_txn_valid = 1'b1;
        applyStimulus(2'd1, 3'b011, 5'd7, 64'd0, 64'h9000, 64'd0);
        checkOutput("rstmid_req", bus.mem_req, 1'b1);
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        exp_txn_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstmid_req_lo", bus.mem_req, 1'b0);
        checkOutput("rstmid_ready_lo", in_ready, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h7777_7777_7777_7777;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        checkOutput("rstmid_no_wb", wb_valid, 1'b0);
        checkOutput("rstmid_req_idle", bus.mem_req, 1'b0);
        checkOutput("rstmid_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        checkOutput("rstmid_no_wb2", wb_valid, 1'b0);

        // Stray grant/response in IDLE does nothing.
        bus.mem_gnt = 1'b1;
        bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        checkOutput("stray_no_wb", wb_valid, 1'b0);
        checkOutput("stray_no_req", bus.mem_req, 1'b0);

`ifdef MEM_STAGE_MISALIGN_FAULT_EN
        faultOp(2'd1, 3'b011, 5'd13, 64'h4004, 64'd0, "ld_misalign");
`else
        memOp(2'd1, 3'b011, 5'd13, 64'h4004, 64'd0, 0, 1, 64'h8899_AABB_CCDD_EEFF, "ld_misalign");
`endif
        aluOp(2'd0, 3'b000, 5'd31, 64'hFFFF_0000_FFFF_0000, "alu_final");

        @(posedge clk); #1;
        checkOutput("wb_queue_drained", exp_wb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
